// File: rtl/sdram_device_model.sv
// Synthesizable single-data-rate SDRAM responder: decodes the command stream, tracks open rows
// per bank, stores/returns byte-masked 32-bit words with CAS latency and flags protocol errors.
module sdram_device_model #(
  parameter int unsigned MEM_ADDR_W = 12,
  parameter int unsigned COL_W      = 10
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [3:0]  sdram_dqm,
  inout  wire  [31:0] sdram_dq,
  output logic        mode_valid,
  output logic [1:0]  cas_lat,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] refresh_count
);

  typedef enum logic [2:0] {
    CmdNop, CmdActive, CmdRead, CmdWrite, CmdPrecharge, CmdRefresh, CmdLoadMode
  } cmd_e;

  cmd_e cmd;

  logic [3:0]  bank_open_q;
  logic [12:0] bank_row_q [4];
  logic        mode_valid_q;
  logic [1:0]  cas_lat_q;
  logic        err_q;
  logic [7:0]  err_count_q;
  logic [15:0] refresh_count_q;

  // Read pipeline: stage k holds a read k edges after its command edge.
  logic [2:0]  pipe_vld_q;
  logic [31:0] pipe_data_q [3];
  logic [3:0]  pipe_dqm_q [3];

  logic [31:0] mem [2**MEM_ADDR_W];

  logic [12:0]           cur_row;
  logic                  cur_open;
  logic [MEM_ADDR_W-1:0] mem_idx;
  logic                  cl3;
  logic                  start_vld;
  logic                  drive_vld;
  logic [31:0]           drive_data;
  logic [3:0]            drive_dqm;
  logic                  rw_bad, act_bad, ref_bad, lm_bad, collision, violation;
  logic                  read_ok, write_ok;

  // cke low turns every command into a NOP.
  always_comb begin
    cmd = CmdNop;
    if (sdram_cke && !sdram_cs_n) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  cmd = CmdActive;
        3'b101:  cmd = CmdRead;
        3'b100:  cmd = CmdWrite;
        3'b010:  cmd = CmdPrecharge;
        3'b001:  cmd = CmdRefresh;
        3'b000:  cmd = CmdLoadMode;
        default: cmd = CmdNop;
      endcase
    end
  end

  assign cur_row  = bank_row_q[sdram_ba];
  assign cur_open = bank_open_q[sdram_ba];
  assign mem_idx  = MEM_ADDR_W'({sdram_ba, cur_row, sdram_addr[COL_W-1:0]});

  assign cl3        = (cas_lat_q == 2'd3);
  assign start_vld  = cl3 ? pipe_vld_q[1] : pipe_vld_q[0];
  assign drive_vld  = cl3 ? pipe_vld_q[2] : pipe_vld_q[1];
  assign drive_data = cl3 ? pipe_data_q[2] : pipe_data_q[1];
  assign drive_dqm  = cl3 ? pipe_dqm_q[2] : pipe_dqm_q[1];

  always_comb begin
    rw_bad    = ((cmd == CmdRead) || (cmd == CmdWrite)) && (!mode_valid_q || !cur_open);
    act_bad   = (cmd == CmdActive) && cur_open;
    ref_bad   = (cmd == CmdRefresh) && (|bank_open_q);
    lm_bad    = (cmd == CmdLoadMode) &&
                ((|bank_open_q) || (sdram_addr[2:0] != 3'b000) || (sdram_addr[6:5] != 2'b01));
    // A write landing on the edge that would start a read drive cancels that drive.
    collision = (cmd == CmdWrite) && start_vld;
    violation = rw_bad || act_bad || ref_bad || lm_bad || collision;
    read_ok   = (cmd == CmdRead) && !rw_bad;
    write_ok  = (cmd == CmdWrite) && !rw_bad;
  end

  for (genvar i = 0; i < 4; i++) begin : g_dq
    assign sdram_dq[8*i +: 8] = (drive_vld && !drive_dqm[i]) ? drive_data[8*i +: 8] : 8'hzz;
  end

  // Backing store has no reset so its contents survive reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset && write_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (!sdram_dqm[i]) mem[mem_idx][8*i +: 8] <= sdram_dq[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bank_open_q     <= '0;
      mode_valid_q    <= 1'b0;
      cas_lat_q       <= 2'd3;
      err_q           <= 1'b0;
      err_count_q     <= '0;
      refresh_count_q <= '0;
      pipe_vld_q      <= '0;
      for (int i = 0; i < 4; i++) bank_row_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        pipe_data_q[i] <= '0;
        pipe_dqm_q[i]  <= '0;
      end
    end else if (sdram_cke) begin
      pipe_vld_q[0]  <= read_ok;
      pipe_vld_q[1]  <= pipe_vld_q[0] & ~(collision & ~cl3);
      pipe_vld_q[2]  <= pipe_vld_q[1] & ~(collision & cl3);
      pipe_data_q[0] <= mem[mem_idx];
      pipe_data_q[1] <= pipe_data_q[0];
      pipe_data_q[2] <= pipe_data_q[1];
      pipe_dqm_q[0]  <= sdram_dqm;
      pipe_dqm_q[1]  <= pipe_dqm_q[0];
      pipe_dqm_q[2]  <= pipe_dqm_q[1];

      case (cmd)
        CmdActive: begin
          bank_open_q[sdram_ba] <= 1'b1;
          bank_row_q[sdram_ba]  <= sdram_addr;
        end
        CmdPrecharge: begin
          if (sdram_addr[10]) bank_open_q <= '0;
          else                bank_open_q[sdram_ba] <= 1'b0;
        end
        CmdRefresh: refresh_count_q <= refresh_count_q + 16'd1;
        CmdLoadMode: begin
          if (!lm_bad) begin
            mode_valid_q <= 1'b1;
            cas_lat_q    <= sdram_addr[5:4];
          end
        end
        default: ;
      endcase

      if (violation) begin
        err_q <= 1'b1;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign mode_valid    = mode_valid_q;
  assign cas_lat       = cas_lat_q;
  assign err           = err_q;
  assign err_count     = err_count_q;
  assign refresh_count = refresh_count_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed, table-driven bench for sdram_device_model. A pullup on dq makes an undriven byte
// read back as 8'hFF, so "Z" is expected as 0xFF in the tables.
module tb_sdram_device_model;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [31:0] ZZ = 32'hFFFF_FFFF;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke;
  logic [3:0]  sdram_dqm;
  wire  [31:0] sdram_dq;
  logic        mode_valid;
  logic [1:0]  cas_lat;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] refresh_count;

  logic        tb_dq_en;
  logic [31:0] tb_dq;

  always #5 clk_clk = ~clk_clk;

  assign sdram_dq = tb_dq_en ? tb_dq : 32'hzzzz_zzzz;
  pullup (sdram_dq);

  sdram_device_model dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .sdram_addr    (sdram_addr),
    .sdram_ba      (sdram_ba),
    .sdram_cs_n    (sdram_cs_n),
    .sdram_ras_n   (sdram_ras_n),
    .sdram_cas_n   (sdram_cas_n),
    .sdram_we_n    (sdram_we_n),
    .sdram_cke     (sdram_cke),
    .sdram_dqm     (sdram_dqm),
    .sdram_dq      (sdram_dq),
    .mode_valid    (mode_valid),
    .cas_lat       (cas_lat),
    .err           (err),
    .err_count     (err_count),
    .refresh_count (refresh_count)
  );

  typedef struct {
    logic        rst;
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [3:0]  dqm;
    logic [31:0] wdata;
    logic        chk_dq;
    logic [31:0] exp_dq;
    logic [7:0]  exp_ec;
    logic [15:0] exp_rc;
    logic        exp_mv;
    logic [1:0]  exp_cl;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(logic rst, logic cke, logic [3:0] cmd, logic [1:0] ba,
                             logic [12:0] addr, logic [3:0] dqm, logic [31:0] wdata,
                             logic chk_dq, logic [31:0] exp_dq, logic [7:0] exp_ec,
                             logic [15:0] exp_rc, logic exp_mv, logic [1:0] exp_cl);
    vec_t t;
    t.rst = rst; t.cke = cke; t.cmd = cmd; t.ba = ba; t.addr = addr; t.dqm = dqm;
    t.wdata = wdata; t.chk_dq = chk_dq; t.exp_dq = exp_dq; t.exp_ec = exp_ec;
    t.exp_rc = exp_rc; t.exp_mv = exp_mv; t.exp_cl = exp_cl;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic cke, input logic [3:0] cmd,
                       input logic [1:0] ba, input logic [12:0] addr, input logic [3:0] dqm,
                       input logic [31:0] wdata);
    @(negedge clk_clk);
    reset_reset = rst;
    sdram_cke   = cke;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    sdram_ba    = ba;
    sdram_addr  = addr;
    sdram_dqm   = dqm;
    tb_dq_en    = (cmd == WR);
    tb_dq       = wdata;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    drive(t.rst, t.cke, t.cmd, t.ba, t.addr, t.dqm, t.wdata);
    if (t.chk_dq) check($sformatf("row%0d dq", idx), sdram_dq, t.exp_dq);
    check($sformatf("row%0d err_count", idx), 32'(err_count), 32'(t.exp_ec));
    check($sformatf("row%0d err", idx), 32'(err), 32'(t.exp_ec != 8'd0));
    check($sformatf("row%0d refresh_count", idx), 32'(refresh_count), 32'(t.exp_rc));
    check($sformatf("row%0d mode_valid", idx), 32'(mode_valid), 32'(t.exp_mv));
    check($sformatf("row%0d cas_lat", idx), 32'(cas_lat), 32'(t.exp_cl));
  endtask

  initial begin
    reset_reset = 1'b1;
    sdram_cke   = 1'b1;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
    sdram_ba = '0; sdram_addr = '0; sdram_dqm = '0;
    tb_dq_en = 1'b0; tb_dq = '0;

    //            rst cke cmd  ba  addr     dqm      wdata         chk dq             ec rc mv cl
    // reset, then a READ with no mode programmed
    vecs.push_back(v(1, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            0, 0, 0, 3));
    vecs.push_back(v(0, 1, RD,  0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 0, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 0, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 0, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 0, 3));
    // CL2 write/read
    vecs.push_back(v(0, 1, LMR, 0, 13'h020, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 2));
    vecs.push_back(v(0, 1, ACT, 1, 13'h005, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 2));
    vecs.push_back(v(0, 1, WR,  1, 13'h004, 4'h0, 32'hDEADBEEF,  0, ZZ,            1, 0, 1, 2));
    vecs.push_back(v(0, 1, RD,  1, 13'h004, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 2));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'hDEADBEEF,  1, 0, 1, 2));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 2));
    // CL3, byte masking on write and on read
    vecs.push_back(v(0, 1, PRE, 0, 13'h400, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 2));
    vecs.push_back(v(0, 1, LMR, 0, 13'h030, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, ACT, 1, 13'h005, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, WR,  1, 13'h008, 4'h0, 32'h11223344,  0, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, WR,  1, 13'h008, 4'h5, 32'hAABBCCDD,  0, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h008, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h008, 4'h8, 32'h0,         1, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'hAA22CC44,  1, 0, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'hFF22CC44,  1, 0, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    // four back-to-back reads
    vecs.push_back(v(0, 1, WR,  1, 13'h000, 4'h0, 32'h01020304,  0, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, WR,  1, 13'h001, 4'h0, 32'h05060708,  0, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, WR,  1, 13'h002, 4'h0, 32'h090A0B0C,  0, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, WR,  1, 13'h003, 4'h0, 32'h0D0E0F10,  0, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h001, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h002, 4'h0, 32'h0,         1, 32'h01020304,  1, 0, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h003, 4'h0, 32'h0,         1, 32'h05060708,  1, 0, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'h090A0B0C,  1, 0, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'h0D0E0F10,  1, 0, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    // refresh with banks open, then after precharge-all
    vecs.push_back(v(0, 1, ACT, 2, 13'h007, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 3));
    vecs.push_back(v(0, 1, REF, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            2, 1, 1, 3));
    vecs.push_back(v(0, 1, PRE, 0, 13'h400, 4'h0, 32'h0,         1, ZZ,            2, 1, 1, 3));
    vecs.push_back(v(0, 1, REF, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            2, 2, 1, 3));
    // read/write collision: READ at E0, WRITE at E2 (CL3)
    vecs.push_back(v(0, 1, ACT, 1, 13'h005, 4'h0, 32'h0,         1, ZZ,            2, 2, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h000, 4'h0, 32'h0,         1, ZZ,            2, 2, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            2, 2, 1, 3));
    vecs.push_back(v(0, 1, WR,  1, 13'h00C, 4'h0, 32'h12345678,  0, ZZ,            3, 2, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            3, 2, 1, 3));
    vecs.push_back(v(0, 1, RD,  1, 13'h00C, 4'h0, 32'h0,         1, ZZ,            3, 2, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            3, 2, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'h12345678,  3, 2, 1, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            3, 2, 1, 3));
    // reset one cycle after a READ cancels the data
    vecs.push_back(v(0, 1, RD,  1, 13'h000, 4'h0, 32'h0,         1, ZZ,            3, 2, 1, 3));
    vecs.push_back(v(1, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            0, 0, 0, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            0, 0, 0, 3));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            0, 0, 0, 3));
    // cke low freezes the pipeline and ignores commands
    vecs.push_back(v(0, 1, LMR, 0, 13'h020, 4'h0, 32'h0,         1, ZZ,            0, 0, 1, 2));
    vecs.push_back(v(0, 1, ACT, 0, 13'h003, 4'h0, 32'h0,         1, ZZ,            0, 0, 1, 2));
    vecs.push_back(v(0, 1, WR,  0, 13'h001, 4'h0, 32'h0BADCAFE,  0, ZZ,            0, 0, 1, 2));
    vecs.push_back(v(0, 1, RD,  0, 13'h001, 4'h0, 32'h0,         1, ZZ,            0, 0, 1, 2));
    vecs.push_back(v(0, 0, ACT, 0, 13'h003, 4'h0, 32'h0,         1, ZZ,            0, 0, 1, 2));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'h0BADCAFE,  0, 0, 1, 2));
    vecs.push_back(v(0, 0, NOP, 0, 13'h000, 4'h0, 32'h0,         1, 32'h0BADCAFE,  0, 0, 1, 2));
    vecs.push_back(v(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            0, 0, 1, 2));
    // illegal LOAD MODE variants leave the mode unchanged
    vecs.push_back(v(0, 1, LMR, 0, 13'h030, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 2));
    vecs.push_back(v(0, 1, PRE, 0, 13'h000, 4'h0, 32'h0,         1, ZZ,            1, 0, 1, 2));
    vecs.push_back(v(0, 1, LMR, 0, 13'h021, 4'h0, 32'h0,         1, ZZ,            2, 0, 1, 2));
    vecs.push_back(v(0, 1, LMR, 0, 13'h050, 4'h0, 32'h0,         1, ZZ,            3, 0, 1, 2));
    vecs.push_back(v(0, 1, LMR, 0, 13'h030, 4'h0, 32'h0,         1, ZZ,            3, 0, 1, 3));

    foreach (vecs[i]) apply(vecs[i], i);

    // err_count saturation: READs to a closed bank are all violations
    for (int i = 0; i < 260; i++) drive(0, 1, RD, 0, 13'h000, 4'h0, 32'h0);
    drive(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0);
    check("sat err_count", 32'(err_count), 32'd255);
    check("sat err", 32'(err), 32'd1);
    drive(0, 1, NOP, 0, 13'h000, 4'h0, 32'h0);
    check("sat dq", sdram_dq, ZZ);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
